// File: rtl/jam_cost_server.sv
// Cost-table server for a JAM job-assignment core: streams in the 8x8 cost table and golden
// answers, sequences the core's reset, then grades the captured result under a watchdog.
module jam_cost_server #(
    parameter int TIMEOUT  = 10000000,
    parameter int CNT_W    = 24,
    parameter int RST_HOLD = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [8:0]       ld_data,
    output logic             jam_rst,
    input  logic [2:0]       W,
    input  logic [2:0]       J,
    output logic [6:0]       Cost,
    input  logic [8:0]       MinCost,
    input  logic [3:0]       MatchCount,
    input  logic             Valid,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       fsm_state
);

    // Load handshake: a beat transfers on any rising edge where ld_valid && ld_ready;
    // ld_ready is high only in LOAD, so beats offered in other states are never taken.

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, HOLD, RUN, DONE} state_t;

    state_t          state, state_d;
    logic [6:0]      idx, idx_d;
    logic [HW-1:0]   hold_cnt, hold_d;
    logic [CNT_W-1:0] cnt_d;
    logic            done_d, pass_d, timeout_d;
    logic [8:0]      gold_min, gold_min_d;
    logic [3:0]      gold_cnt, gold_cnt_d;
    logic            beat_acc;
    logic [6:0]      tbl [64];

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        hold_d     = hold_cnt;
        cnt_d      = cycle_cnt;
        done_d     = done;
        pass_d     = pass;
        timeout_d  = timeout;
        gold_min_d = gold_min;
        gold_cnt_d = gold_cnt;
        ld_ready   = 1'b0;
        jam_rst    = 1'b1;
        beat_acc   = 1'b0;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    beat_acc = 1'b1;
                    idx_d    = idx + 7'd1;
                    if (idx == 7'd64) gold_min_d = ld_data;
                    if (idx == 7'd65) begin
                        gold_cnt_d = ld_data[3:0];
                        hold_d     = '0;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                hold_d = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                jam_rst = 1'b0;
                // A result arriving on the final watchdog cycle still counts as a result.
                if (Valid) begin
                    done_d    = 1'b1;
                    pass_d    = (MinCost == gold_min) && (MatchCount == gold_cnt);
                    timeout_d = 1'b0;
                    state_d   = DONE;
                end else if (cycle_cnt == RUN_LAST) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cycle_cnt + 1'b1;
                end
            end
            DONE: ;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= LOAD;
            idx       <= '0;
            hold_cnt  <= '0;
            cycle_cnt <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            gold_min  <= '0;
            gold_cnt  <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            hold_cnt  <= hold_d;
            cycle_cnt <= cnt_d;
            done      <= done_d;
            pass      <= pass_d;
            timeout   <= timeout_d;
            gold_min  <= gold_min_d;
            gold_cnt  <= gold_cnt_d;
        end
    end

    // The table is deliberately left out of reset so a mid-run RST keeps its contents.
    always_ff @(posedge CLK) begin
        if (!RST && beat_acc && !idx[6]) tbl[idx[5:0]] <= ld_data[6:0];
    end

    assign Cost      = tbl[{W, J}];
    assign fsm_state = state;

endmodule

// File: tb/tb_jam_cost_server.sv
// Bench for jam_cost_server: directed load/run/grade scenarios checked every cycle against an
// integer-level model of the server, plus hand-computed literal expectations.
module tb_jam_cost_server;

    localparam int TIMEOUT  = 100;
    localparam int CNT_W    = 24;
    localparam int RST_HOLD = 3;

    logic             CLK = 1'b0;
    logic             RST, ld_valid, ld_ready, jam_rst, Valid, done, pass, timeout;
    logic [8:0]       ld_data, MinCost;
    logic [2:0]       W, J;
    logic [6:0]       Cost;
    logic [3:0]       MatchCount;
    logic [CNT_W-1:0] cycle_cnt;
    logic [1:0]       fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    jam_cost_server #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD)) dut (
        .CLK(CLK), .RST(RST), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .jam_rst(jam_rst), .W(W), .J(J), .Cost(Cost), .MinCost(MinCost),
        .MatchCount(MatchCount), .Valid(Valid), .done(done), .pass(pass),
        .timeout(timeout), .cycle_cnt(cycle_cnt), .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: phase 0=loading, 1=reset hold, 2=running, 3=finished.
    int         m_phase, m_beats, m_hold_left, m_cnt;
    bit         m_started = 0, m_loaded = 0, m_done, m_pass, m_timeout;
    logic [6:0] m_tbl [64];
    logic [8:0] m_gold_min;
    logic [3:0] m_gold_cnt;

    always @(posedge CLK) begin
        if (RST) begin
            m_phase = 0; m_beats = 0; m_cnt = 0;
            m_done = 0; m_pass = 0; m_timeout = 0;
            m_gold_min = 0; m_gold_cnt = 0;
            m_started = 1;
        end else if (m_phase == 0) begin
            if (ld_valid) begin
                if (m_beats < 64) m_tbl[m_beats] = ld_data[6:0];
                if (m_beats == 63) m_loaded = 1;
                if (m_beats == 64) m_gold_min = ld_data;
                if (m_beats == 65) begin
                    m_gold_cnt = ld_data[3:0];
                    m_phase = 1; m_hold_left = RST_HOLD;
                end
                m_beats++;
            end
        end else if (m_phase == 1) begin
            m_hold_left--;
            if (m_hold_left == 0) begin m_phase = 2; m_cnt = 0; end
        end else if (m_phase == 2) begin
            if (Valid) begin
                m_done = 1; m_timeout = 0; m_phase = 3;
                m_pass = (MinCost == m_gold_min) && (MatchCount == m_gold_cnt);
            end else if (m_cnt == TIMEOUT - 1) begin
                m_done = 1; m_timeout = 1; m_pass = 0; m_phase = 3;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_started) begin
            check("ld_ready", ld_ready, m_phase == 0);
            check("jam_rst", jam_rst, m_phase != 2);
            check("done", done, m_done);
            check("pass", pass, m_pass);
            check("timeout", timeout, m_timeout);
            check("cycle_cnt", cycle_cnt, m_cnt);
            if (m_loaded) check("cost", Cost, m_tbl[{W, J}]);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [6:0] cost_of(input int mode, input int b);
        if (mode == 0) return 7'((b / 8) + (b % 8));
        return 7'((b * 37 + 11) % 128);
    endfunction

    task automatic do_reset();
        RST = 1'b1; Valid = 1'b0; ld_valid = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    // Upper ld_data bits on cost beats carry junk that must not reach the table.
    task automatic load(input int mode, input logic [8:0] gmin, input logic [8:0] gcnt_beat,
                        input int gap_at);
        for (int b = 0; b < 66; b++) begin
            if (b == gap_at) begin
                ld_valid = 1'b0; ld_data = 9'h1FF;
                tick(); tick();
            end
            ld_valid = 1'b1;
            ld_data  = (b < 64) ? {2'b10, cost_of(mode, b)} : ((b == 64) ? gmin : gcnt_beat);
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (jam_rst && n < 20) begin tick(); n++; end
        check("run_entry_jam_rst", jam_rst, 0);
    endtask

    task automatic pulse_valid(input logic [8:0] mc, input logic [3:0] cnt);
        Valid = 1'b1; MinCost = mc; MatchCount = cnt;
        tick();
        Valid = 1'b0;
    endtask

    task automatic sweep_costs();
        for (int a = 0; a < 64; a++) begin
            {W, J} = 6'(a);
            #1;
            check("sweep_cost", Cost, m_tbl[a]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;
        RST = 1'b1; ld_valid = 1'b0; ld_data = '0; W = '0; J = '0;
        MinCost = '0; MatchCount = '0; Valid = 1'b0;
        tick(); tick();
        RST = 1'b0;
        check("rst_ld_ready", ld_ready, 1);
        check("rst_jam_rst", jam_rst, 1);
        check("rst_done", done, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);

        // Load W+J costs with a two-cycle stall, then read back same-cycle.
        load(0, 9'd7, 9'd1, 10);
        W = 3'd5; J = 3'd3; #1; check("cost_5_3", Cost, 8);
        W = 3'd7; J = 3'd7; #1; check("cost_7_7", Cost, 14);
        W = 3'd0; J = 3'd1; #1; check("cost_0_1", Cost, 1);
        n = 0;
        while (jam_rst && n < 20) begin n++; tick(); end
        check("jam_rst_hold_cycles", n, RST_HOLD);
        check("run_start_cnt", cycle_cnt, 0);

        // Matching result at cycle 20; then load beats in DONE must be ignored.
        repeat (20) tick();
        pulse_valid(9'd7, 4'd1);
        check("t3_done", done, 1);
        check("t3_pass", pass, 1);
        check("t3_timeout", timeout, 0);
        check("t3_cnt", cycle_cnt, 20);
        ld_valid = 1'b1; ld_data = 9'h07F;
        repeat (5) tick();
        ld_valid = 1'b0;
        check("t3_cnt_frozen", cycle_cnt, 20);
        check("t3_ld_ready", ld_ready, 0);
        sweep_costs();

        // Valid during HOLD is ignored; wrong MinCost fails.
        do_reset();
        load(1, 9'd7, 9'd1, -1);
        Valid = 1'b1; MinCost = 9'd7; MatchCount = 4'd1;
        n = 0;
        while (jam_rst && n < 20) begin tick(); n++; end
        Valid = 1'b0;
        check("t4_hold_valid_ignored", done, 0);
        repeat (5) tick();
        pulse_valid(9'd8, 4'd1);
        check("t4_done", done, 1);
        check("t4_pass", pass, 0);
        check("t4_cnt", cycle_cnt, 5);

        // Full-width gold: MinCost 0x1C7, MatchCount from ld_data[3:0] only.
        do_reset();
        load(1, 9'h1C7, 9'h1F3, -1);
        wait_run();
        repeat (3) tick();
        pulse_valid(9'h1C7, 4'd2);
        check("wide_cnt_mismatch_pass", pass, 0);
        do_reset();
        load(1, 9'h1C7, 9'h1F3, -1);
        wait_run();
        pulse_valid(9'h1C7, 4'd3);
        check("wide_match_pass", pass, 1);
        check("wide_match_cnt", cycle_cnt, 0);

        // Watchdog expiry with no result.
        do_reset();
        load(1, 9'd7, 9'd1, -1);
        wait_run();
        n = 0;
        while (!done && n < 200) begin tick(); n++; end
        check("to_done", done, 1);
        check("to_cycles", n, TIMEOUT);
        check("to_timeout", timeout, 1);
        check("to_pass", pass, 0);
        check("to_cnt", cycle_cnt, TIMEOUT - 1);

        // Result on the last watchdog cycle wins over the timeout.
        do_reset();
        load(1, 9'd7, 9'd1, -1);
        wait_run();
        repeat (TIMEOUT - 1) tick();
        pulse_valid(9'd7, 4'd1);
        check("edge_done", done, 1);
        check("edge_pass", pass, 1);
        check("edge_timeout", timeout, 0);
        check("edge_cnt", cycle_cnt, TIMEOUT - 1);

        // RST mid-run returns to LOAD and keeps the table.
        do_reset();
        load(1, 9'd7, 9'd1, -1);
        wait_run();
        repeat (10) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_ld_ready", ld_ready, 1);
        check("mid_rst_jam_rst", jam_rst, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_cnt", cycle_cnt, 0);
        W = 3'd0; J = 3'd0; #1; check("mid_rst_cost_0_0", Cost, 11);
        W = 3'd7; J = 3'd7; #1; check("mid_rst_cost_7_7", Cost, 38);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
